// File: rtl/mode_status_tx_if.sv
// Signal bundle between the mode source (mode_select side) and the status transmitter.
// The transmitter uses the slave modport; the mode source side uses master.
interface mode_status_tx_if;
    logic manual_on;
    logic auto_on;
    logic tx_serial;
    logic tx_busy;
    logic tx_done;

    modport master (
        output manual_on, auto_on,
        input  tx_serial, tx_busy, tx_done
    );

    modport slave (
        input  manual_on, auto_on,
        output tx_serial, tx_busy, tx_done
    );
endinterface

// File: rtl/mode_status_tx.sv
// Reports the current drive mode back to the Arduino as 8N1 UART frames.
// A frame goes out on every status change, once after reset, and on an optional heartbeat.
//
// state   | meaning
// S_IDLE  | line high, launch a frame when pending is set
// S_START | start bit (line low)
// S_DATA  | eight data bits, LSB first
// S_STOP  | stop bit (line high)
module mode_status_tx #(
    parameter int unsigned CLKS_PER_BIT     = 434,
    parameter int unsigned HEARTBEAT_CYCLES = 50_000_000
) (
    input  logic            clk,
    input  logic            reset,
    mode_status_tx_if.slave bus
);
    localparam int unsigned     BT_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned     HB_W    = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
    localparam logic [BT_W-1:0] BT_LAST = BT_W'(CLKS_PER_BIT - 1);
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          state_q, state_d;
    logic [BT_W-1:0] bit_tmr_q, bit_tmr_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      code_q;
    logic [HB_W-1:0] hb_q, hb_d;
    logic            pending_q, pending_d;
    logic            tx_serial_q, tx_serial_d;
    logic            tx_busy_q, tx_busy_d;
    logic            tx_done_q, tx_done_d;

    logic [7:0]      status_code;
    logic            change;
    logic            hb_wrap;
    logic            bit_end;

    // Same byte values the Arduino uses to command the mode.
    always_comb begin
        case ({bus.manual_on, bus.auto_on})
            2'b10:   status_code = 8'h00;
            2'b01:   status_code = 8'hFF;
            2'b00:   status_code = 8'hA5;
            default: status_code = 8'h3C;
        endcase
    end

    assign change  = (status_code != code_q);
    assign hb_wrap = (HEARTBEAT_CYCLES != 0) && (hb_q == HB_LAST);
    assign bit_end = (bit_tmr_q == BT_LAST);
    assign hb_d    = ((HEARTBEAT_CYCLES == 0) || hb_wrap) ? '0 : hb_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        bit_tmr_d   = bit_tmr_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        pending_d   = pending_q;
        tx_done_d   = 1'b0;
        tx_serial_d = 1'b1;

        if (change || hb_wrap) begin
            pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                // Launch clears pending even if a change lands now: the byte latched is already current.
                if (pending_q) begin
                    shift_d   = status_code;
                    pending_d = 1'b0;
                    bit_tmr_d = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    bit_tmr_d = '0;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end else begin
                    bit_tmr_d = bit_tmr_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    bit_tmr_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    bit_tmr_d = bit_tmr_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    bit_tmr_d = '0;
                    tx_done_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    bit_tmr_d = bit_tmr_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line and busy are registered from the next state so they stay glitch-free.
        case (state_d)
            S_START: tx_serial_d = 1'b0;
            S_DATA:  tx_serial_d = shift_d[bit_idx_d];
            default: tx_serial_d = 1'b1;
        endcase
        tx_busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bit_tmr_q   <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            code_q      <= 8'hA5;
            hb_q        <= '0;
            pending_q   <= 1'b1;
            tx_serial_q <= 1'b1;
            tx_busy_q   <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_tmr_q   <= bit_tmr_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            code_q      <= status_code;
            hb_q        <= hb_d;
            pending_q   <= pending_d;
            tx_serial_q <= tx_serial_d;
            tx_busy_q   <= tx_busy_d;
            tx_done_q   <= tx_done_d;
        end
    end

    assign bus.tx_serial = tx_serial_q;
    assign bus.tx_busy   = tx_busy_q;
    assign bus.tx_done   = tx_done_q;
endmodule

// File: tb/tb_mode_status_tx.sv
// Bench for mode_status_tx: two instances (no heartbeat / heartbeat=100), 4 clocks per bit.
// A line monitor captures whole frames; tests push expected frames and compare on pop.
module tb_mode_status_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a;
    logic reset_b;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    mode_status_tx_if ifa ();
    mode_status_tx_if ifb ();

    mode_status_tx #(.CLKS_PER_BIT(4), .HEARTBEAT_CYCLES(0)) dut_a (
        .clk(clk), .reset(reset_a), .bus(ifa.slave)
    );
    mode_status_tx #(.CLKS_PER_BIT(4), .HEARTBEAT_CYCLES(100)) dut_b (
        .clk(clk), .reset(reset_b), .bus(ifb.slave)
    );

    // Offsets 0..39 are the frame, offset 40 is the IDLE cycle that follows it.
    typedef struct {
        logic [40:0] line;
        logic [40:0] busy;
        logic [40:0] done;
        int          start;
    } frame_t;

    typedef struct {
        logic [7:0] val;
        int         start;
    } exp_t;

    localparam logic [40:0] BUSY_EXP = {1'b0, {40{1'b1}}};
    localparam logic [40:0] DONE_EXP = {1'b1, 40'h0};

    frame_t rxq_a[$];
    frame_t rxq_b[$];
    exp_t   exp_a[$];
    exp_t   exp_b[$];
    logic   mon_act[2];
    int     mon_off[2];
    frame_t mon_fr[2];
    int     done_cnt[2];

    initial begin
        for (int c = 0; c < 2; c++) begin
            mon_act[c] = 1'b0;
            mon_off[c] = 0;
            done_cnt[c] = 0;
        end
    end

    function automatic logic [40:0] exp_line(input logic [7:0] v);
        logic [9:0]  bits;
        logic [40:0] l;
        bits = {1'b1, v, 1'b0};
        for (int k = 0; k < 40; k++) l[k] = bits[k / 4];
        l[40] = 1'b1;
        return l;
    endfunction

    function automatic void mon_step(input int c, input logic s, input logic b,
                                     input logic d, input logic r);
        if (d === 1'b1) done_cnt[c]++;
        if (r) begin
            mon_act[c] = 1'b0;
            return;
        end
        if (!mon_act[c]) begin
            if (s !== 1'b0) return;
            mon_act[c] = 1'b1;
            mon_off[c] = 0;
            mon_fr[c].start = cyc;
        end else begin
            mon_off[c]++;
        end
        mon_fr[c].line[mon_off[c]] = s;
        mon_fr[c].busy[mon_off[c]] = b;
        mon_fr[c].done[mon_off[c]] = d;
        if (mon_off[c] == 40) begin
            mon_act[c] = 1'b0;
            if (c == 0) rxq_a.push_back(mon_fr[c]);
            else        rxq_b.push_back(mon_fr[c]);
        end
    endfunction

    always @(negedge clk) begin
        mon_step(0, ifa.tx_serial, ifa.tx_busy, ifa.tx_done, reset_a);
        mon_step(1, ifb.tx_serial, ifb.tx_busy, ifb.tx_done, reset_b);
    end

    task automatic pop_frame(input int c, output frame_t f, output exp_t e, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        f  = '{line: '0, busy: '0, done: '0, start: 0};
        e  = '{val: 8'h00, start: -1};
        while (((c == 0) ? rxq_a.size() : rxq_b.size()) == 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (c == 0 && rxq_a.size() != 0 && exp_a.size() != 0) begin
            f = rxq_a.pop_front();
            e = exp_a.pop_front();
            ok = 1'b1;
        end else if (c == 1 && rxq_b.size() != 0 && exp_b.size() != 0) begin
            f = rxq_b.pop_front();
            e = exp_b.pop_front();
            ok = 1'b1;
        end
    endtask

    task automatic set_a(input logic man, input logic aut, output int k);
        @(posedge clk);
        #1;
        k = cyc;
        ifa.manual_on = man;
        ifa.auto_on   = aut;
    endtask

    task automatic test_reset();
        frame_t f; exp_t e; bit ok; int r;
        reset_a = 1'b1; reset_b = 1'b1;
        ifa.manual_on = 1'b0; ifa.auto_on = 1'b0;
        ifb.manual_on = 1'b0; ifb.auto_on = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (ifa.tx_serial !== 1'b1) begin failures++; $display("FAIL rst_serial got=%b want=1", ifa.tx_serial); end
        checks++; if (ifa.tx_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", ifa.tx_busy); end
        checks++; if (ifa.tx_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b want=0", ifa.tx_done); end
        @(posedge clk);
        #1;
        r = cyc;
        exp_a.push_back('{val: 8'hA5, start: r + 1});
        reset_a = 1'b0;
        pop_frame(0, f, e, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rst_frame timeout got=none want=frame"); end
        else begin
            checks++; if (f.line !== exp_line(e.val)) begin failures++; $display("FAIL rst_line got=%h want=%h", f.line, exp_line(e.val)); end
            checks++; if (f.busy !== BUSY_EXP || f.done !== DONE_EXP) begin failures++; $display("FAIL rst_busy_done got=%h/%h want=%h/%h", f.busy, f.done, BUSY_EXP, DONE_EXP); end
            checks++; if (f.start !== e.start) begin failures++; $display("FAIL rst_start got=%0d want=%0d", f.start, e.start); end
        end
        checks++; if (done_cnt[0] !== 1) begin failures++; $display("FAIL rst_done_count got=%0d want=1", done_cnt[0]); end
    endtask

    task automatic test_manual_rise();
        frame_t f; exp_t e; bit ok; int k;
        repeat (5) @(posedge clk);
        set_a(1'b1, 1'b0, k);
        exp_a.push_back('{val: 8'h00, start: k + 2});
        pop_frame(0, f, e, ok);
        checks++; if (!ok) begin failures++; $display("FAIL manual_frame timeout got=none want=frame"); end
        else begin
            checks++; if (f.line !== exp_line(e.val)) begin failures++; $display("FAIL manual_line got=%h want=%h", f.line, exp_line(e.val)); end
            checks++; if (f.busy !== BUSY_EXP || f.done !== DONE_EXP) begin failures++; $display("FAIL manual_busy_done got=%h/%h want=%h/%h", f.busy, f.done, BUSY_EXP, DONE_EXP); end
            checks++; if (f.start !== e.start) begin failures++; $display("FAIL manual_start got=%0d want=%0d", f.start, e.start); end
        end
    endtask

    task automatic test_changes_in_frame();
        frame_t f; exp_t e; bit ok; int k; int k2; int dummy;
        set_a(1'b0, 1'b0, k);
        exp_a.push_back('{val: 8'hA5, start: k + 2});
        pop_frame(0, f, e, ok);
        checks++; if (!ok || f.line !== exp_line(e.val) || f.start !== e.start) begin failures++; $display("FAIL init_frame got=%h@%0d want=%h@%0d", f.line, f.start, exp_line(e.val), e.start); end
        repeat (3) @(posedge clk);
        set_a(1'b1, 1'b0, k2);
        exp_a.push_back('{val: 8'h00, start: k2 + 2});
        exp_a.push_back('{val: 8'hFF, start: k2 + 43});
        repeat (7) @(posedge clk);
        set_a(1'b0, 1'b1, dummy);
        repeat (7) @(posedge clk);
        set_a(1'b1, 1'b0, dummy);
        repeat (7) @(posedge clk);
        set_a(1'b0, 1'b1, dummy);
        for (int i = 0; i < 2; i++) begin
            pop_frame(0, f, e, ok);
            checks++; if (!ok) begin failures++; $display("FAIL chg_frame%0d timeout got=none want=frame", i); end
            else begin
                checks++; if (f.line !== exp_line(e.val)) begin failures++; $display("FAIL chg_line%0d got=%h want=%h", i, f.line, exp_line(e.val)); end
                checks++; if (f.busy !== BUSY_EXP || f.done !== DONE_EXP) begin failures++; $display("FAIL chg_busy_done%0d got=%h/%h want=%h/%h", i, f.busy, f.done, BUSY_EXP, DONE_EXP); end
                checks++; if (f.start !== e.start) begin failures++; $display("FAIL chg_start%0d got=%0d want=%0d", i, f.start, e.start); end
            end
        end
        repeat (60) @(negedge clk);
        checks++; if (rxq_a.size() !== 0) begin failures++; $display("FAIL chg_extra_frames got=%0d want=0", rxq_a.size()); end
    endtask

    task automatic test_illegal();
        frame_t f; exp_t e; bit ok; int k;
        set_a(1'b1, 1'b1, k);
        exp_a.push_back('{val: 8'h3C, start: k + 2});
        pop_frame(0, f, e, ok);
        checks++; if (!ok) begin failures++; $display("FAIL illegal_frame timeout got=none want=frame"); end
        else begin
            checks++; if (f.line !== exp_line(e.val)) begin failures++; $display("FAIL illegal_line got=%h want=%h", f.line, exp_line(e.val)); end
            checks++; if (f.start !== e.start) begin failures++; $display("FAIL illegal_start got=%0d want=%0d", f.start, e.start); end
        end
    endtask

    task automatic test_reset_mid();
        frame_t f; exp_t e; bit ok; int k; int r;
        repeat (3) @(posedge clk);
        set_a(1'b0, 1'b0, k);
        // Frame starts at edge k+2; edge k+19 is offset 17, inside data bit 3.
        repeat (18) @(posedge clk);
        #1;
        reset_a = 1'b1;
        ifa.manual_on = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (ifa.tx_serial !== 1'b1) begin failures++; $display("FAIL mid_rst_serial got=%b want=1", ifa.tx_serial); end
        checks++; if (ifa.tx_busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b want=0", ifa.tx_busy); end
        repeat (2) @(posedge clk);
        #1;
        r = cyc;
        exp_a.push_back('{val: 8'h00, start: r + 1});
        reset_a = 1'b0;
        pop_frame(0, f, e, ok);
        checks++; if (!ok) begin failures++; $display("FAIL mid_frame timeout got=none want=frame"); end
        else begin
            checks++; if (f.line !== exp_line(e.val)) begin failures++; $display("FAIL mid_line got=%h want=%h", f.line, exp_line(e.val)); end
            checks++; if (f.busy !== BUSY_EXP || f.done !== DONE_EXP) begin failures++; $display("FAIL mid_busy_done got=%h/%h want=%h/%h", f.busy, f.done, BUSY_EXP, DONE_EXP); end
            checks++; if (f.start !== e.start) begin failures++; $display("FAIL mid_start got=%0d want=%0d", f.start, e.start); end
        end
        repeat (50) @(negedge clk);
        checks++; if (rxq_a.size() !== 0) begin failures++; $display("FAIL mid_extra_frames got=%0d want=0", rxq_a.size()); end
    endtask

    task automatic test_heartbeat();
        frame_t f; exp_t e; bit ok; int r;
        @(posedge clk);
        #1;
        r = cyc;
        for (int i = 0; i < 3; i++) exp_b.push_back('{val: 8'hFF, start: r + 1 + 100 * i});
        reset_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pop_frame(1, f, e, ok);
            checks++; if (!ok) begin failures++; $display("FAIL hb_frame%0d timeout got=none want=frame", i); end
            else begin
                checks++; if (f.line !== exp_line(e.val)) begin failures++; $display("FAIL hb_line%0d got=%h want=%h", i, f.line, exp_line(e.val)); end
                checks++; if (f.start !== e.start) begin failures++; $display("FAIL hb_start%0d got=%0d want=%0d", i, f.start, e.start); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_manual_rise();
        test_changes_in_frame();
        test_illegal();
        test_reset_mid();
        test_heartbeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
